// File: rtl/pace_generator.sv
// Frame/step pace generator: divides enabled clocks into frames of DELAY+1 cycles
// and frames into steps of period+1 frames, with a saturating step counter.
module pace_generator #(
   parameter int unsigned DELAY_W     = 20,
   parameter int unsigned DELAY       = 833332,
   parameter int unsigned FRAME_W     = 4,
   parameter int unsigned PERIOD_INIT = 14,
   parameter int unsigned CNT_W       = 8
) (
   input  logic               clock,
   input  logic               resetn,
   input  logic               enable,
   input  logic               clr,
   input  logic               load,
   input  logic [FRAME_W-1:0] period_in,
   output logic               frame_tick,
   output logic               step,
   output logic [CNT_W-1:0]   step_count,
   output logic [FRAME_W-1:0] period
);

   localparam logic [DELAY_W-1:0] DELAY_RELOAD = DELAY_W'(DELAY);
   localparam logic [FRAME_W-1:0] PERIOD_RST   = FRAME_W'(PERIOD_INIT);

   logic [DELAY_W-1:0] delay_cnt;
   logic [FRAME_W-1:0] frame_cnt;

   logic frame_cycle;
   logic step_cycle;

   assign frame_cycle = enable && (delay_cnt == '0);
   assign step_cycle  = frame_cycle && (frame_cnt == '0);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         delay_cnt  <= DELAY_RELOAD;
         frame_cnt  <= PERIOD_RST;
         period     <= PERIOD_RST;
         step_count <= '0;
         frame_tick <= 1'b0;
         step       <= 1'b0;
      end else if (clr || load) begin
         // clr and load both restart the frame; load supplies the new period to
         // the frame counter directly so a combined clr+load uses the new value.
         delay_cnt  <= DELAY_RELOAD;
         frame_tick <= 1'b0;
         step       <= 1'b0;
         if (load) begin
            period    <= period_in;
            frame_cnt <= period_in;
         end else begin
            frame_cnt <= period;
         end
         if (clr) begin
            step_count <= '0;
         end
      end else begin
         frame_tick <= frame_cycle;
         step       <= step_cycle;
         if (enable) begin
            if (delay_cnt == '0) begin
               delay_cnt <= DELAY_RELOAD;
               if (frame_cnt == '0) begin
                  frame_cnt <= period;
               end else begin
                  frame_cnt <= frame_cnt - 1'b1;
               end
            end else begin
               delay_cnt <= delay_cnt - 1'b1;
            end
         end
         if (step_cycle && (step_count != '1)) begin
            step_count <= step_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_pace_generator.sv
// Directed bench for pace_generator with DELAY=3, PERIOD_INIT=2, CNT_W=2.
module tb_pace_generator;

   localparam int unsigned DELAY_W = 4;
   localparam int unsigned FRAME_W = 4;
   localparam int unsigned CNT_W   = 2;

   logic               clock = 1'b0;
   logic               resetn;
   logic               enable;
   logic               clr;
   logic               load;
   logic [FRAME_W-1:0] period_in;
   logic               frame_tick;
   logic               step;
   logic [CNT_W-1:0]   step_count;
   logic [FRAME_W-1:0] period;

   int n_assert = 0;
   int n_fail   = 0;

   pace_generator #(
      .DELAY_W    (DELAY_W),
      .DELAY      (3),
      .FRAME_W    (FRAME_W),
      .PERIOD_INIT(2),
      .CNT_W      (CNT_W)
   ) dut (
      .clock     (clock),
      .resetn    (resetn),
      .enable    (enable),
      .clr       (clr),
      .load      (load),
      .period_in (period_in),
      .frame_tick(frame_tick),
      .step      (step),
      .step_count(step_count),
      .period    (period)
   );

   always #5 clock = ~clock;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic ft, input logic st,
                        input logic [CNT_W-1:0] cnt, input logic [FRAME_W-1:0] per);
      logic [7:0] obs;
      logic [7:0] exp;
      obs = {frame_tick, step, step_count, period};
      exp = {ft, st, cnt, per};
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed tick/step/count/period=%b expected %b", tag, obs, exp);
      end
   endtask

   initial begin
      logic             e_ft;
      logic             e_st;
      int               e_cnt;
      logic [FRAME_W-1:0] e_per;

      resetn    = 1'b1;
      enable    = 1'b1;
      clr       = 1'b0;
      load      = 1'b0;
      period_in = '0;
      #1 resetn = 1'b0;
      #1 check("reset state", 1'b0, 1'b0, 2'd0, 4'd2);

      // free run with enable high: ticks every 4, steps every 12, count saturates at 3
      @(negedge clock) resetn = 1'b1;
      for (int k = 1; k <= 52; k++) begin
         tick();
         e_cnt = (k / 12 > 3) ? 3 : k / 12;
         check($sformatf("freerun edge %0d", k), (k % 4) == 0, (k % 12) == 0,
               2'(e_cnt), 4'd2);
      end

      // asynchronous reset between edges while frame_tick and count are nonzero
      #2 resetn = 1'b0;
      #1 check("async reset A", 1'b0, 1'b0, 2'd0, 4'd2);

      // enable dropped for edges 6..10 delays every later pulse by 5 clocks
      @(negedge clock) resetn = 1'b1;
      for (int k = 1; k <= 21; k++) begin
         enable = !(k >= 6 && k <= 10);
         tick();
         e_ft = (k == 4) || (k == 13) || (k == 17) || (k == 21);
         check($sformatf("enable gap edge %0d", k), e_ft, k == 17,
               (k >= 17) ? 2'd1 : 2'd0, 4'd2);
      end
      enable = 1'b1;

      tick();
      #2 resetn = 1'b0;
      #1 check("async reset B", 1'b0, 1'b0, 2'd0, 4'd2);

      // load period 0 at edge 2, clr on frame cycle 22, load 3 at 27,
      // clr+load period 1 at 28 with enable low
      @(negedge clock) resetn = 1'b1;
      for (int k = 1; k <= 44; k++) begin
         enable    = (k != 28);
         load      = (k == 2) || (k == 27) || (k == 28);
         clr       = (k == 22) || (k == 28);
         period_in = (k == 2) ? 4'd0 : (k == 27) ? 4'd3 : 4'd1;
         tick();
         e_ft = (k == 6) || (k == 10) || (k == 14) || (k == 18) || (k == 26) ||
                (k == 32) || (k == 36) || (k == 40) || (k == 44);
         e_st = (k == 6) || (k == 10) || (k == 14) || (k == 18) || (k == 26) ||
                (k == 36) || (k == 44);
         if (k < 6)       e_cnt = 0;
         else if (k < 10) e_cnt = 1;
         else if (k < 14) e_cnt = 2;
         else if (k < 22) e_cnt = 3;
         else if (k < 26) e_cnt = 0;
         else if (k < 28) e_cnt = 1;
         else if (k < 36) e_cnt = 0;
         else if (k < 44) e_cnt = 1;
         else             e_cnt = 2;
         if (k < 2)       e_per = 4'd2;
         else if (k < 27) e_per = 4'd0;
         else if (k < 28) e_per = 4'd3;
         else             e_per = 4'd1;
         check($sformatf("clr/load edge %0d", k), e_ft, e_st, 2'(e_cnt), e_per);
      end
      clr  = 1'b0;
      load = 1'b0;

      // reset must restore PERIOD_INIT over a loaded period
      #2 resetn = 1'b0;
      #1 check("async reset C", 1'b0, 1'b0, 2'd0, 4'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pace_generator.md
PACE_GENERATOR -- requirements
Module: pace_generator

Interface
REQ-001 SHALL have parameter DELAY_W, default 20: width of the sub-frame delay counter.
REQ-002 SHALL have parameter DELAY, default 833332: delay reload value; frame period is DELAY+1 enabled clocks (50 MHz / 60).
REQ-003 SHALL have parameter FRAME_W, default 4: width of the frame counter and period register.
REQ-004 SHALL have parameter PERIOD_INIT, default 14: period register reset value; step period is PERIOD_INIT+1 frames.
REQ-005 SHALL have parameter CNT_W, default 8: width of step_count.
REQ-006 SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-007 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port enable, input, 1: high lets the counters advance; low freezes them.
REQ-009 SHALL have port clr, input, 1: synchronous restart of the counters and step_count.
REQ-010 SHALL have port load, input, 1: synchronous load of period_in into the period register.
REQ-011 SHALL have port period_in, input, FRAME_W: new step period minus one.
REQ-012 SHALL have port frame_tick, output, 1: registered one-clock pulse per frame.
REQ-013 SHALL have port step, output, 1: registered one-clock pulse per step.
REQ-014 SHALL have port step_count, output, CNT_W: number of steps since reset/clr, saturating.
REQ-015 SHALL have port period, output, FRAME_W: current period register value.

Function
REQ-016 The delay counter SHALL be a DELAY_W-bit down-counter; on an enabled cycle it reloads DELAY if it is 0, otherwise it decrements by 1.
REQ-017 A "frame cycle" SHALL be an enabled cycle in which the delay counter equals 0.
REQ-018 frame_tick SHALL be high in the clock following each frame cycle and low otherwise, giving exactly one pulse per DELAY+1 enabled clocks.
REQ-019 The frame counter SHALL be a FRAME_W-bit down-counter that changes only on frame cycles: it reloads period if it is 0, otherwise it decrements by 1.
REQ-020 step SHALL be high in the clock following a frame cycle in which the frame counter equals 0; step SHALL therefore coincide with frame_tick, once every period+1 frames.
REQ-021 With period = 0, every frame_tick SHALL be accompanied by step.
REQ-022 step_count SHALL increment by 1 in the same edge that sets step, and SHALL saturate at 2^CNT_W-1 with no wrap.
REQ-023 With enable low, both counters and step_count SHALL hold, and frame_tick and step SHALL be 0 in the following clock.
REQ-024 load=1 SHALL write period_in to period, reload the frame counter with period_in and the delay counter with DELAY, and force both pulses to 0 in the next clock, regardless of enable.
REQ-025 clr=1 SHALL reload the delay counter with DELAY and the frame counter with period, clear step_count, and force both pulses to 0 in the next clock, regardless of enable; period is unchanged.
REQ-026 clr and load together SHALL apply the load to period and the frame counter, restart the delay counter, clear step_count, and force both pulses to 0.
REQ-027 clr and load SHALL take priority over enable; enable changes mid-frame SHALL preserve the counter values.

Reset
REQ-028 resetn low SHALL immediately set: delay counter to DELAY, frame counter and period to PERIOD_INIT, step_count to 0, frame_tick to 0, step to 0.
REQ-029 Reset asserted mid-frame SHALL discard all progress.
REQ-030 After reset release, the first frame_tick SHALL occur DELAY+1 enabled clocks later.

Verification (DELAY=3, PERIOD_INIT=2, CNT_W=2)
REQ-031 Release reset with enable held high -> frame_tick pulses on clocks 4, 8, 12, ...; step pulses on clocks 12, 24, ...; step_count reads 1, 2, 3 and then holds at 3.
REQ-032 Drop enable for 5 clocks at clock 6 -> no pulses while low; the next frame_tick arrives 5 clocks later than REQ-031 (clock 13).
REQ-033 Pulse load with period_in=0 at clock 2 -> period=0; frame_tick and step both pulse every 4 clocks counted from the load.
REQ-034 Pulse clr on the same clock as a frame cycle -> no pulse in the next clock; step_count=0; next frame_tick 4 clocks later.
REQ-035 Assert resetn low asynchronously between edges mid-run -> all outputs 0 and period=2 immediately, before the next clock edge.
REQ-036 Assert clr and load together with period_in=1 -> period=1, step_count=0; steps every 2 frames (8 clocks) after release.
